// File: rtl/trng_ctrl_if.sv
// trng_ctrl_if: control, entropy-bank and random-word handshake signals of
// the TRNG sequencer. The master modport is the sequencer's view; the slave
// modport is the view of whatever drives it and consumes its words.
interface trng_ctrl_if #(
    parameter int WORD_WIDTH = 8
) ();
    logic                  start;
    logic                  stop;
    logic                  ro_enable;
    logic                  ro_bit;
    logic [WORD_WIDTH-1:0] rnd_data;
    logic                  rnd_valid;
    logic                  rnd_ready;
    logic                  busy;
    logic                  health_fail;

    modport master (
        input  start, stop, ro_bit, rnd_ready,
        output ro_enable, rnd_data, rnd_valid, busy, health_fail
    );

    modport slave (
        output start, stop, ro_bit, rnd_ready,
        input  ro_enable, rnd_data, rnd_valid, busy, health_fail
    );
endinterface

// File: rtl/trng_ctrl.sv
// trng_ctrl: sequencer for a ring-oscillator entropy bank.
// Enables the bank, waits out a warm-up interval, decimates the combined
// bit stream into WORD_WIDTH-bit words, hands them out over valid/ready and
// runs a repetition-count health test whose failure is sticky until reset.
// Optional build macro TRNG_CTRL_VON_NEUMANN_EN: raw samples are debiased in
// pairs (10 -> 1, 01 -> 0, 00/11 dropped); the health test still sees every
// raw sample.
module trng_ctrl #(
    parameter int WORD_WIDTH    = 8,
    parameter int SAMPLE_DIV    = 4,
    parameter int WARMUP_CYCLES = 16,
    parameter int REP_LIMIT     = 32
) (
    input  logic        clock,
    input  logic        reset,
    trng_ctrl_if.master bus
);
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) + 1 : 1;
    localparam int BIT_W  = $clog2(WORD_WIDTH) + 1;
    localparam int REP_W  = $clog2(REP_LIMIT) + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [WARM_W-1:0]     warm_cnt_r;
    logic [DIV_W-1:0]      div_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [WORD_WIDTH-1:0] shreg_r;
    logic [REP_W-1:0]      rep_cnt_r;
    logic                  last_r;
    logic                  last_valid_r;
    logic                  stop_pending_r;
    logic                  ro_enable_r;
    logic                  rnd_valid_r;
    logic                  busy_r;
    logic                  health_fail_r;
    logic [WORD_WIDTH-1:0] rnd_data_r;

    logic                  sample_s;
    logic                  accept_s;
    logic                  acc_bit_s;
    logic                  word_done_s;
    logic [WORD_WIDTH-1:0] word_s;
    logic [REP_W-1:0]      rep_next_s;
    logic                  fail_s;
    logic                  enter_collect_s;
    logic                  enter_from_warm_s;
    logic                  active_s;

`ifdef TRNG_CTRL_VON_NEUMANN_EN
    logic pair_full_r;
    logic pair_first_r;
`endif

    // Next-state, sampling strobes and health-test decision
    always_comb begin
        state_s           = state_r;
        sample_s          = 1'b0;
        accept_s          = 1'b0;
        acc_bit_s         = 1'b0;
        word_done_s       = 1'b0;
        word_s            = shreg_r;
        rep_next_s        = rep_cnt_r;
        fail_s            = 1'b0;
        enter_collect_s   = 1'b0;
        enter_from_warm_s = 1'b0;
        active_s          = 1'b0;

        sample_s = (state_r == ST_COLLECT) && (div_r == DIV_W'(SAMPLE_DIV - 1));

        // A new run starts on the first sample after warm-up or on a change.
        if (!last_valid_r || (bus.ro_bit != last_r)) begin
            rep_next_s = REP_W'(1);
        end else if (rep_cnt_r == {REP_W{1'b1}}) begin
            rep_next_s = rep_cnt_r;
        end else begin
            rep_next_s = rep_cnt_r + REP_W'(1);
        end
        fail_s = sample_s && (rep_next_s == REP_W'(REP_LIMIT));

`ifdef TRNG_CTRL_VON_NEUMANN_EN
        accept_s  = sample_s && pair_full_r && (pair_first_r != bus.ro_bit);
        acc_bit_s = pair_first_r;
`else
        accept_s  = sample_s;
        acc_bit_s = bus.ro_bit;
`endif
        word_s      = {shreg_r[WORD_WIDTH-2:0], acc_bit_s};
        word_done_s = accept_s && (bit_cnt_r == BIT_W'(WORD_WIDTH - 1));

        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_s = ST_WARMUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (bus.stop) begin
                    state_s = ST_IDLE;
                end else if (warm_cnt_r == WARM_W'(0)) begin
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_WARMUP;
                end
            end
            ST_COLLECT: begin
                // A health failure takes precedence over stop and word completion.
                if (fail_s) begin
                    state_s = ST_FAIL;
                end else if (bus.stop) begin
                    state_s = ST_IDLE;
                end else if (word_done_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (bus.rnd_ready) begin
                    if (stop_pending_r || bus.stop) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_FAIL: begin
                state_s = ST_FAIL;
            end
            default: begin
                state_s = ST_FAIL;
            end
        endcase

        enter_collect_s   = (state_s == ST_COLLECT) && (state_r != ST_COLLECT);
        enter_from_warm_s = (state_s == ST_COLLECT) && (state_r == ST_WARMUP);

        case (state_s)
            ST_WARMUP, ST_COLLECT, ST_HOLD: active_s = 1'b1;
            default:                        active_s = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Warm-up countdown, sample divider and accepted-bit counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            warm_cnt_r <= WARM_W'(0);
            div_r      <= DIV_W'(0);
            bit_cnt_r  <= BIT_W'(0);
            shreg_r    <= {WORD_WIDTH{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && (state_s == ST_WARMUP)) begin
                warm_cnt_r <= WARM_W'(WARMUP_CYCLES - 1);
            end else if ((state_r == ST_WARMUP) && (warm_cnt_r != WARM_W'(0))) begin
                warm_cnt_r <= warm_cnt_r - WARM_W'(1);
            end

            if (enter_collect_s) begin
                div_r     <= DIV_W'(0);
                bit_cnt_r <= BIT_W'(0);
                shreg_r   <= {WORD_WIDTH{1'b0}};
            end else if (state_r == ST_COLLECT) begin
                if (sample_s) begin
                    div_r <= DIV_W'(0);
                end else begin
                    div_r <= div_r + DIV_W'(1);
                end
                if (accept_s) begin
                    shreg_r <= word_s;
                    if (word_done_s) begin
                        bit_cnt_r <= BIT_W'(0);
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
            end
        end
    end

    // Repetition-count health test state; frozen outside COLLECT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt_r    <= REP_W'(0);
            last_r       <= 1'b0;
            last_valid_r <= 1'b0;
        end else if (enter_from_warm_s) begin
            rep_cnt_r    <= REP_W'(1);
            last_valid_r <= 1'b0;
        end else if (sample_s) begin
            rep_cnt_r    <= rep_next_s;
            last_r       <= bus.ro_bit;
            last_valid_r <= 1'b1;
        end
    end

`ifdef TRNG_CTRL_VON_NEUMANN_EN
    // Von Neumann pair register: holds the first raw sample of each pair
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pair_full_r  <= 1'b0;
            pair_first_r <= 1'b0;
        end else if (enter_collect_s) begin
            pair_full_r  <= 1'b0;
            pair_first_r <= 1'b0;
        end else if (sample_s) begin
            pair_full_r <= ~pair_full_r;
            if (!pair_full_r) begin
                pair_first_r <= bus.ro_bit;
            end
        end
    end
`endif

    // A stop seen while holding a word is remembered until the word is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stop_pending_r <= 1'b0;
        end else if (state_s == ST_IDLE) begin
            stop_pending_r <= 1'b0;
        end else if ((state_r == ST_HOLD) && bus.stop) begin
            stop_pending_r <= 1'b1;
        end
    end

    // Registered outputs derived from the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ro_enable_r   <= 1'b0;
            busy_r        <= 1'b0;
            rnd_valid_r   <= 1'b0;
            health_fail_r <= 1'b0;
            rnd_data_r    <= {WORD_WIDTH{1'b0}};
        end else begin
            ro_enable_r   <= active_s;
            busy_r        <= active_s;
            rnd_valid_r   <= (state_s == ST_HOLD);
            health_fail_r <= (state_s == ST_FAIL);
            if ((state_r == ST_COLLECT) && (state_s == ST_HOLD)) begin
                rnd_data_r <= word_s;
            end
        end
    end

    assign bus.ro_enable   = ro_enable_r;
    assign bus.busy        = busy_r;
    assign bus.rnd_valid   = rnd_valid_r;
    assign bus.health_fail = health_fail_r;
    assign bus.rnd_data    = rnd_data_r;
endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl: directed stimulus with a word scoreboard. Expected words are
// queued when a stimulus sequence is issued; a negedge monitor compares every
// presented word against the queue head and pops it on the handshake.
// Build with TRNG_CTRL_VON_NEUMANN_EN defined to exercise the extractor.
module tb_trng_ctrl;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    trng_ctrl_if #(.WORD_WIDTH(8)) bus ();

    trng_ctrl #(
        .WORD_WIDTH   (8),
        .SAMPLE_DIV   (4),
        .WARMUP_CYCLES(16),
        .REP_LIMIT    (32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold one raw bit across a full sample window
    task automatic feed(input logic b);
        bus.ro_bit = b;
        tick(4);
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic handshake();
        bus.rnd_ready = 1'b1;
        tick(1);
        bus.rnd_ready = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset && bus.rnd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected no word", bus.rnd_data);
            end else begin
                check("word_data", bus.rnd_data, exp_q[0]);
                if (bus.rnd_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.ro_bit    = 1'b0;
        bus.rnd_ready = 1'b0;
        tick(2);
        check("rst_ro_enable", bus.ro_enable, 1'b0);
        check("rst_rnd_valid", bus.rnd_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_health_fail", bus.health_fail, 1'b0);
        check("rst_rnd_data", bus.rnd_data, 8'h00);
        reset = 1'b0;
        tick(2);

`ifndef TRNG_CTRL_VON_NEUMANN_EN
        // Basic word: alternating 1,0 -> 0xAA
        start_run();
        check("warm_ro_enable", bus.ro_enable, 1'b1);
        check("warm_busy", bus.busy, 1'b1);
        tick(16);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 8; i++) begin
            feed((i % 2) == 0);
            if (i == 6) check("valid_after_7", bus.rnd_valid, 1'b0);
        end
        check("valid_after_8", bus.rnd_valid, 1'b1);
        handshake();
        check("valid_drop", bus.rnd_valid, 1'b0);
        check("collect_again_busy", bus.busy, 1'b1);

        // Stop during COLLECT after 3 samples
        for (int i = 0; i < 3; i++) feed(1'b1);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("stop_collect_ro_enable", bus.ro_enable, 1'b0);
        check("stop_collect_busy", bus.busy, 1'b0);
        tick(20);

        // Backpressure: pattern 1,1,1,0 -> 0xEE, held 20 cycles
        pat = 8'hEE;
        start_run();
        tick(16);
        exp_q.push_back(8'hEE);
        for (int i = 0; i < 8; i++) feed(pat[7-i]);
        check("bp_valid", bus.rnd_valid, 1'b1);
        tick(20);
        check("bp_valid_held", bus.rnd_valid, 1'b1);
        check("bp_ro_enable_held", bus.ro_enable, 1'b1);
        exp_q.push_back(8'hEE);
        handshake();
        check("bp_no_rewarm_en", bus.ro_enable, 1'b1);
        check("bp_busy", bus.busy, 1'b1);
        for (int i = 0; i < 8; i++) feed(pat[7-i]);
        check("bp_second_valid", bus.rnd_valid, 1'b1);

        // Stop during HOLD: word still delivered, then IDLE
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("stop_hold_valid", bus.rnd_valid, 1'b1);
        check("stop_hold_busy", bus.busy, 1'b1);
        tick(3);
        handshake();
        check("stop_hold_idle_busy", bus.busy, 1'b0);
        check("stop_hold_idle_en", bus.ro_enable, 1'b0);
        check("stop_hold_idle_valid", bus.rnd_valid, 1'b0);

        // start and stop together in IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick(3);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_busy", bus.busy, 1'b0);
        check("start_stop_en", bus.ro_enable, 1'b0);

        // Health: stuck-at-0 with a ready consumer; words at samples 8,16,24,
        // sample 32 fails and its word is never presented.
        bus.rnd_ready = 1'b1;
        bus.ro_bit    = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        start_run();
        tick(146);
        check("health_before_32", bus.health_fail, 1'b0);
        check("health_before_busy", bus.busy, 1'b1);
        tick(1);
`else
        // Von Neumann: raw 1,0 repeated -> every pair gives 1 -> 0xFF
        start_run();
        tick(16);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) begin
            feed((i % 2) == 0);
            if (i == 14) check("vn_valid_after_15", bus.rnd_valid, 1'b0);
        end
        check("vn_valid_after_16", bus.rnd_valid, 1'b1);
        handshake();
        check("vn_valid_drop", bus.rnd_valid, 1'b0);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("vn_stop_busy", bus.busy, 1'b0);

        // Raw 1,1,0,0 repeated -> every pair discarded
        start_run();
        tick(16);
        for (int i = 0; i < 24; i++) feed(((i / 2) % 2) == 0);
        check("vn_discard_valid", bus.rnd_valid, 1'b0);
        check("vn_discard_busy", bus.busy, 1'b1);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;

        // Health on raw samples: stuck-at-0 fails at the 32nd sample
        bus.ro_bit = 1'b0;
        start_run();
        tick(140);
        check("health_before_32", bus.health_fail, 1'b0);
        check("health_before_busy", bus.busy, 1'b1);
        tick(4);
`endif
        check("health_fail", bus.health_fail, 1'b1);
        check("health_ro_enable", bus.ro_enable, 1'b0);
        check("health_busy", bus.busy, 1'b0);
        check("health_valid", bus.rnd_valid, 1'b0);
        bus.rnd_ready = 1'b0;
        bus.start     = 1'b1;
        tick(5);
        bus.start = 1'b0;
        check("fail_sticky", bus.health_fail, 1'b1);
        check("fail_start_ignored", bus.ro_enable, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        // Reset clears FAIL, then reset asserted mid-COLLECT
        reset = 1'b1;
        #1;
        check("reset_clears_fail", bus.health_fail, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(1);
        bus.ro_bit = 1'b1;
        start_run();
        tick(22);
        check("pre_reset_busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_en", bus.ro_enable, 1'b0);
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_valid", bus.rnd_valid, 1'b0);
        check("async_rst_data", bus.rnd_data, 8'h00);
        tick(2);
        reset = 1'b0;
        tick(40);
        check("post_rst_idle_busy", bus.busy, 1'b0);
        check("post_rst_idle_en", bus.ro_enable, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
